ram_arbiter: RTL and testbench

//  Owns the processor's byte-wide program/data RAM and shares its single port among three

---
 rtl/ram_arbiter_if.sv | 48 ++++
 rtl/ram_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_ram_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_arbiter_if
// Bundles the three-requester RAM access bus that is shared by the loader,
// the instruction fetch unit and the data load/store unit.
//
// Parameters
//   WIDTH  data width of one RAM word
//   AW     address width per requester
//
// Signals (requester i occupies slice i of the packed vectors)
//   req[2:0]           access request, one bit per requester
//   we[2:0]            write enable, qualified by req
//   addr[3*AW-1:0]     requester i address at [i*AW +: AW]
//   wdata[3*WIDTH-1:0] requester i write data at [i*WIDTH +: WIDTH]
//   gnt[2:0]           one-hot grant (combinational)
//   rvalid[2:0]        one-hot read-data-valid (registered)
//   rdata              registered read data
//   ready              RAM clear finished, accesses are served
//   addr_err           one-cycle pulse after an out-of-range granted access
//
// Modports
//   master : requester side (drives req/we/addr/wdata)
//   slave  : arbiter side (drives gnt/rvalid/rdata/ready/addr_err)
// ---------------------------------------------------------------------------
interface ram_arbiter_if #(
   parameter int WIDTH = 8,
   parameter int AW    = 6
);
   logic [2:0]         req;
   logic [2:0]         we;
   logic [3*AW-1:0]    addr;
   logic [3*WIDTH-1:0] wdata;
   logic [2:0]         gnt;
   logic [2:0]         rvalid;
   logic [WIDTH-1:0]   rdata;
   logic               ready;
   logic               addr_err;

   modport master (
      output req, we, addr, wdata,
      input  gnt, rvalid, rdata, ready, addr_err
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, rvalid, rdata, ready, addr_err
   );
endinterface

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Owns the processor's single-port program/data RAM and shares it among
// three requesters: 0 = loader, 1 = instruction fetch, 2 = data load/store.
// After reset the RAM is zero-cleared one word per cycle; afterwards at most
// one access per cycle is served. The loader has fixed top priority, fetch
// and data alternate round-robin when both are requesting.
//
// Parameters
//   WIDTH    data width of one RAM word
//   RAMSIZE  number of RAM words
//   AW       requester address width, 2**AW >= RAMSIZE
//
// Ports
//   clk      clock, all state on the rising edge
//   reset_n  asynchronous active-low reset
//   bus      ram_arbiter_if slave modport (req/we/addr/wdata in,
//            gnt/rvalid/rdata/ready/addr_err out)
//
// Timing
//   The access happens at the rising edge where req[i] & gnt[i]. Read data
//   and rvalid[i] appear in the following cycle; addr_err pulses in that same
//   cycle if the granted address was >= RAMSIZE.
// ---------------------------------------------------------------------------
module ram_arbiter #(
   parameter int WIDTH   = 8,
   parameter int RAMSIZE = 64,
   parameter int AW      = 6
) (
   input  logic         clk,
   input  logic         reset_n,
   ram_arbiter_if.slave bus
);

   // Width of a physical RAM index; address bits above it only matter for
   // the range check.
   localparam int              IW         = (RAMSIZE > 1) ? $clog2(RAMSIZE) : 1;
   localparam logic [AW:0]     ADDR_LIMIT = (AW+1)'(RAMSIZE);
   localparam logic [IW-1:0]   CLR_LAST   = IW'(RAMSIZE - 1);

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_RUN   = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t           state_reg, state_next;
   logic [IW-1:0]    clr_ptr_reg, clr_ptr_next;
   // Round-robin pointer between fetch and data:
   // 0 = fetch (requester 1) wins a tie, 1 = data (requester 2) wins.
   logic             rr_reg, rr_next;
   logic [2:0]       rvalid_reg;
   logic             rd_hit_reg;
   logic             addr_err_reg;

   // RAM array and its registered read port
   logic [WIDTH-1:0] ram [RAMSIZE];
   logic [WIDTH-1:0] ram_q;

   // ------------------------------------------------------------------
   // Per-requester views of the packed address / data vectors
   // ------------------------------------------------------------------
   logic [AW-1:0]    req_addr  [3];
   logic [WIDTH-1:0] req_wdata [3];

   for (genvar gi = 0; gi < 3; gi++) begin : g_slice
      assign req_addr[gi]  = bus.addr[gi*AW +: AW];
      assign req_wdata[gi] = bus.wdata[gi*WIDTH +: WIDTH];
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= S_CLEAR;
         clr_ptr_reg <= '0;
         rr_reg      <= 1'b0;
      end else begin
         state_reg   <= state_next;
         clr_ptr_reg <= clr_ptr_next;
         rr_reg      <= rr_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state, clear pointer, winner selection, round-robin update
   // ------------------------------------------------------------------
   logic [2:0] gnt_c;

   always_comb begin
      state_next   = state_reg;
      clr_ptr_next = clr_ptr_reg;
      rr_next      = rr_reg;
      gnt_c        = 3'b000;

      case (state_reg)
         S_CLEAR: begin
            // Requests stay pending while the RAM is being cleared.
            clr_ptr_next = clr_ptr_reg + 1'b1;
            if (clr_ptr_reg == CLR_LAST) begin
               state_next   = S_RUN;
               clr_ptr_next = '0;
            end
         end

         S_RUN: begin
            if (bus.req[0]) begin
               gnt_c = 3'b001;
            end else if (bus.req[1] && bus.req[2]) begin
               gnt_c = rr_reg ? 3'b100 : 3'b010;
            end else if (bus.req[1]) begin
               gnt_c = 3'b010;
            end else if (bus.req[2]) begin
               gnt_c = 3'b100;
            end

            // Only fetch/data grants move the pointer; a loader grant
            // leaves the fetch/data alternation where it was.
            if (gnt_c[1]) begin
               rr_next = 1'b1;
            end else if (gnt_c[2]) begin
               rr_next = 1'b0;
            end
         end

         default: begin
            state_next = S_CLEAR;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Selected access
   // ------------------------------------------------------------------
   logic [1:0]       sel_idx;
   logic             acc_valid;
   logic [AW-1:0]    sel_addr;
   logic             sel_we;
   logic [WIDTH-1:0] sel_wdata;
   logic             sel_oob;
   logic             rd_en;

   always_comb begin
      sel_idx = 2'd0;
      if (gnt_c[2]) begin
         sel_idx = 2'd2;
      end else if (gnt_c[1]) begin
         sel_idx = 2'd1;
      end
   end

   // A grant is only ever issued to an active request, so any grant bit
   // means an access takes place at the coming edge.
   assign acc_valid = |gnt_c;
   assign sel_addr  = req_addr[sel_idx];
   assign sel_we    = bus.we[sel_idx];
   assign sel_wdata = req_wdata[sel_idx];
   assign sel_oob   = ({1'b0, sel_addr} >= ADDR_LIMIT);
   assign rd_en     = acc_valid && !sel_we && !sel_oob;

   // ------------------------------------------------------------------
   // RAM write port: the clear sequence and granted writes share it.
   // Out-of-range writes are dropped here.
   // ------------------------------------------------------------------
   logic             ram_we;
   logic [IW-1:0]    ram_waddr;
   logic [WIDTH-1:0] ram_wdata;

   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = '0;
      ram_wdata = '0;
      if (state_reg == S_CLEAR) begin
         ram_we    = 1'b1;
         ram_waddr = clr_ptr_reg;
      end else if (acc_valid && sel_we && !sel_oob) begin
         ram_we    = 1'b1;
         ram_waddr = sel_addr[IW-1:0];
         ram_wdata = sel_wdata;
      end
   end

   // RAM contents carry no reset; the clear sequence initialises them.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram[ram_waddr] <= ram_wdata;
      end
      if (rd_en) begin
         ram_q <= ram[sel_addr[IW-1:0]];
      end
   end

   // ------------------------------------------------------------------
   // Read response and error pulse
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rvalid_reg   <= 3'b000;
         rd_hit_reg   <= 1'b0;
         addr_err_reg <= 1'b0;
      end else begin
         // Out-of-range reads still pulse rvalid, only with zero data.
         rvalid_reg   <= (acc_valid && !sel_we) ? gnt_c : 3'b000;
         rd_hit_reg   <= rd_en;
         addr_err_reg <= acc_valid && sel_oob;
      end
   end

   // The RAM output register has no reset, so read data is gated by a
   // resettable hit flag: zero after reset and for out-of-range reads.
   assign bus.rdata    = rd_hit_reg ? ram_q : '0;
   assign bus.rvalid   = rvalid_reg;
   assign bus.addr_err = addr_err_reg;
   assign bus.gnt      = gnt_c;
   assign bus.ready    = (state_reg == S_RUN);

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
// Directed scenarios followed by a randomized phase for ram_arbiter
// (WIDTH=8, RAMSIZE=64, AW=7 so out-of-range addresses 64..127 exist).
// Expected grants, read data and error pulses come from a behavioural
// model: an array of RAM words, a clear-cycle counter and a "favoured"
// requester number.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;

   localparam int WIDTH   = 8;
   localparam int RAMSIZE = 64;
   localparam int AW      = 7;

   logic clk;
   logic reset_n;

   ram_arbiter_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

   ram_arbiter #(
      .WIDTH  (WIDTH),
      .RAMSIZE(RAMSIZE),
      .AW     (AW)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Behavioural model
   int m_mem [RAMSIZE];
   bit m_ready;
   int m_clr;
   int m_fav;         // requester (1 or 2) that wins a fetch/data tie
   int last_grant;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_rq(input int i, input bit r, input bit w, input int a, input int d);
      bus.req[i]             = r;
      bus.we[i]              = w;
      bus.addr[i*AW +: AW]   = a[AW-1:0];
      bus.wdata[i*WIDTH +: WIDTH] = d[WIDTH-1:0];
   endtask

   task automatic clear_rq();
      for (int i = 0; i < 3; i++) set_rq(i, 1'b0, 1'b0, 0, 0);
   endtask

   // One clock cycle: check the grant before the edge, predict the outcome,
   // then check the registered response just after the edge.
   task automatic step();
      int w;
      int a;
      logic [2:0] eg;
      logic [2:0] ev;
      logic [7:0] ed;
      logic       ee;
      @(negedge clk);
      w = -1;
      if (m_ready) begin
         if (bus.req[0])                    w = 0;
         else if (bus.req[1] && bus.req[2]) w = m_fav;
         else if (bus.req[1])               w = 1;
         else if (bus.req[2])               w = 2;
      end
      eg = (w >= 0) ? 3'(1 << w) : 3'b000;
      check("ready", {31'b0, bus.ready}, {31'b0, m_ready});
      check("gnt", {29'b0, bus.gnt}, {29'b0, eg});
      ev = 3'b000;
      ed = 8'h00;
      ee = 1'b0;
      last_grant = w;
      if (w >= 0) begin
         a = int'(bus.addr[w*AW +: AW]);
         ee = (a >= RAMSIZE);
         if (bus.we[w]) begin
            if (a < RAMSIZE) m_mem[a] = int'(bus.wdata[w*WIDTH +: WIDTH]);
         end else begin
            ev = eg;
            ed = (a < RAMSIZE) ? 8'(m_mem[a]) : 8'h00;
         end
         if (w != 0) m_fav = 3 - w;
      end
      if (!m_ready) begin
         m_clr++;
         if (m_clr == RAMSIZE) begin
            m_ready = 1'b1;
            for (int k = 0; k < RAMSIZE; k++) m_mem[k] = 0;
         end
      end
      @(posedge clk);
      #1;
      check("rvalid", {29'b0, bus.rvalid}, {29'b0, ev});
      check("addr_err", {31'b0, bus.addr_err}, {31'b0, ee});
      if (ev != 3'b000) check("rdata", {24'b0, bus.rdata}, {24'b0, ed});
      $display("t=%0t w=%0d gnt=%b rvalid=%b rdata=%h addr_err=%b ready=%b",
               $time, w, eg, bus.rvalid, bus.rdata, bus.addr_err, bus.ready);
   endtask

   // Hold reset across one rising edge, check the reset state, release.
   task automatic do_reset();
      reset_n = 1'b0;
      m_ready = 1'b0;
      m_clr   = 0;
      m_fav   = 1;
      @(posedge clk);
      #1;
      check("rst_ready", {31'b0, bus.ready}, 32'd0);
      check("rst_gnt", {29'b0, bus.gnt}, 32'd0);
      check("rst_rvalid", {29'b0, bus.rvalid}, 32'd0);
      check("rst_rdata", {24'b0, bus.rdata}, 32'd0);
      check("rst_addr_err", {31'b0, bus.addr_err}, 32'd0);
      reset_n = 1'b1;
   endtask

   logic [7:0] t2_tbl [4];
   bit         pend [3];
   int         ready_cycle;

   initial begin
      reset_n = 1'b0;
      clear_rq();
      t2_tbl[0] = 8'h02; t2_tbl[1] = 8'h00; t2_tbl[2] = 8'h10; t2_tbl[3] = 8'h00;

      // 1. Clear sequence with all requests pending
      do_reset();
      set_rq(0, 1'b1, 1'b1, 0, 8'h02);
      set_rq(1, 1'b1, 1'b0, 0, 0);
      set_rq(2, 1'b1, 1'b0, 5, 0);
      ready_cycle = -1;
      for (int c = 1; c <= RAMSIZE + 4 && ready_cycle < 0; c++) begin
         @(posedge clk);
         #1;
         if (bus.ready) ready_cycle = c;
      end
      check("ready_cycle", ready_cycle, RAMSIZE);
      // Model catches up: clear completes, no access happened yet.
      m_ready = 1'b1;
      m_clr   = RAMSIZE;
      for (int k = 0; k < RAMSIZE; k++) m_mem[k] = 0;

      // 2. Loader writes 0..3, then fetch reads them back
      step();
      set_rq(0, 1'b1, 1'b1, 1, 8'h00); step();
      set_rq(0, 1'b1, 1'b1, 2, 8'h10); step();
      set_rq(0, 1'b1, 1'b1, 3, 8'h00); step();
      set_rq(0, 1'b0, 1'b0, 0, 0);
      step();
      step();
      clear_rq();
      for (int k = 0; k < 4; k++) begin
         set_rq(1, 1'b1, 1'b0, k, 0);
         step();
         check("t2_rdata", {24'b0, bus.rdata}, {24'b0, t2_tbl[k]});
      end
      clear_rq();

      // 3. Fetch/data alternation, loader interjects mid-sequence
      set_rq(1, 1'b1, 1'b0, 1, 0);
      set_rq(2, 1'b1, 1'b0, 2, 0);
      for (int k = 0; k < 3; k++) step();
      set_rq(0, 1'b1, 1'b0, 7, 0);
      step();
      check("t3_loader", {29'b0, bus.rvalid}, 32'd1);
      set_rq(0, 1'b0, 1'b0, 0, 0);
      for (int k = 0; k < 4; k++) step();
      clear_rq();

      // 4. Data write then fetch read of the same address
      set_rq(2, 1'b1, 1'b1, 18, 8'h2A);
      step();
      clear_rq();
      set_rq(1, 1'b1, 1'b0, 18, 0);
      step();
      check("t4_rdata", {24'b0, bus.rdata}, 32'h2A);
      clear_rq();

      // 5. Boundary addresses
      set_rq(2, 1'b1, 1'b0, 63, 0); step();
      check("t5_rd63", {24'b0, bus.rdata}, 32'h00);
      set_rq(2, 1'b1, 1'b1, 64, 8'h55); step();
      check("t5_wr64_err", {31'b0, bus.addr_err}, 32'd1);
      set_rq(2, 1'b1, 1'b0, 64, 0); step();
      check("t5_rd64_err", {31'b0, bus.addr_err}, 32'd1);
      set_rq(2, 1'b1, 1'b0, 0, 0); step();
      check("t5_rd0_kept", {24'b0, bus.rdata}, 32'h02);
      clear_rq();
      step();

      // 6a. Reset in the middle of a read response
      set_rq(2, 1'b1, 1'b0, 2, 0);
      @(negedge clk);
      @(posedge clk);
      #1;
      check("t6_rvalid_pre", {29'b0, bus.rvalid}, 32'd4);
      reset_n = 1'b0;
      #1;
      check("t6_rvalid_async", {29'b0, bus.rvalid}, 32'd0);
      check("t6_ready_async", {31'b0, bus.ready}, 32'd0);
      do_reset();

      // 6b. Reset during clear at clr_ptr=30, then a full clear again
      set_rq(1, 1'b1, 1'b0, 9, 0);
      for (int k = 0; k < 30; k++) step();
      reset_n = 1'b0;
      #1;
      check("t6_ready_low", {31'b0, bus.ready}, 32'd0);
      do_reset();
      for (int k = 0; k < RAMSIZE + 1; k++) step();
      clear_rq();

      // Randomized phase: requesters hold their request until granted
      for (int i = 0; i < 3; i++) pend[i] = 1'b0;
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 3; i++) begin
            if (!pend[i] && $urandom_range(0, 99) < ((i == 0) ? 12 : 60)) begin
               int a;
               if ($urandom_range(0, 9) == 0) a = $urandom_range(RAMSIZE, 2**AW - 1);
               else                           a = $urandom_range(0, 15);
               set_rq(i, 1'b1, 1'($urandom_range(0, 1)), a, int'($urandom_range(0, 255)));
               pend[i] = 1'b1;
            end
         end
         step();
         if (last_grant >= 0) begin
            pend[last_grant] = 1'b0;
            set_rq(last_grant, 1'b0, 1'b0, 0, 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
